// File: rtl/regfile_sb.sv
// regfile_sb: NREG x XLEN register file with write bypass, optional zero register and busy scoreboard
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  input  logic            ren1,
  input  logic            ren2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  output logic            hazard,
  output logic [AW:0]     busy_cnt
);
  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy;
  logic wv, iv, inc, dec;
  function automatic logic ok(input logic [AW-1:0] a);
    return (int'(a) < NREG) && !(ZERO_REG != 0 && a == '0);
  endfunction
  // set wins over clear on the same address, so that case never decrements
  always_comb begin
    wv = we && ok(waddr);
    iv = iss_en && ok(iss_addr);
    inc = iv && !busy[iss_addr];
    dec = wv && busy[waddr] && !(iv && iss_addr == waddr);
  end
  always_comb begin
    rdata1 = !ok(raddr1) ? '0 : (we && waddr == raddr1) ? wdata : mem[raddr1];
    rdata2 = !ok(raddr2) ? '0 : (we && waddr == raddr2) ? wdata : mem[raddr2];
    hazard = (ren1 && ok(raddr1) && busy[raddr1] && !(we && waddr == raddr1)) ||
             (ren2 && ok(raddr2) && busy[raddr2] && !(we && waddr == raddr2));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem <= '{default: '0};
      busy <= '0;
      busy_cnt <= '0;
    end else begin
      if (wv) begin
        mem[waddr] <= wdata;
        busy[waddr] <= 1'b0;
      end
      if (iv) busy[iss_addr] <= 1'b1;
      busy_cnt <= busy_cnt + (AW+1)'(inc) - (AW+1)'(dec);
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of regfile_sb at 32 registers and at a 24-register depth
module tb_regfile_sb;
  logic clk = 0, rst = 1;
  logic [4:0] raddr1, raddr2, waddr, iss_addr;
  logic ren1, ren2, we, iss_en, hazard;
  logic [31:0] rdata1, rdata2, wdata;
  logic [5:0] busy_cnt;
  logic [4:0] b_raddr1, b_raddr2, b_waddr, b_iss_addr;
  logic b_ren1, b_ren2, b_we, b_iss_en, b_hazard;
  logic [31:0] b_rdata1, b_rdata2, b_wdata;
  logic [5:0] b_busy_cnt;
  int n_chk = 0, n_pass = 0;

  regfile_sb dut (
    .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2), .ren1(ren1), .ren2(ren2),
    .rdata1(rdata1), .rdata2(rdata2), .we(we), .waddr(waddr), .wdata(wdata),
    .iss_en(iss_en), .iss_addr(iss_addr), .hazard(hazard), .busy_cnt(busy_cnt)
  );

  regfile_sb #(.NREG(24)) dut_b (
    .clk(clk), .rst(rst), .raddr1(b_raddr1), .raddr2(b_raddr2), .ren1(b_ren1), .ren2(b_ren2),
    .rdata1(b_rdata1), .rdata2(b_rdata2), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
    .iss_en(b_iss_en), .iss_addr(b_iss_addr), .hazard(b_hazard), .busy_cnt(b_busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    we = 0; iss_en = 0; waddr = 0; wdata = 0; iss_addr = 0;
    b_we = 0; b_iss_en = 0; b_waddr = 0; b_wdata = 0; b_iss_addr = 0;
  endtask

  initial begin
    idle();
    raddr1 = 5; raddr2 = 0; ren1 = 0; ren2 = 0;
    b_raddr1 = 0; b_raddr2 = 0; b_ren1 = 0; b_ren2 = 0;
    #12 rst = 0;
    #1;
    chk("reset_rdata", rdata1, 0);
    chk("reset_hazard", hazard, 0);
    chk("reset_cnt", busy_cnt, 0);
    tick();
    // write r5 and issue r7, then reset asynchronously between edges
    we = 1; waddr = 5; wdata = 32'hDEADBEEF; iss_en = 1; iss_addr = 7;
    tick();
    idle();
    ren2 = 1; raddr2 = 7;
    #1;
    chk("pre_rst_rdata", rdata1, 32'hDEADBEEF);
    chk("pre_rst_hazard", hazard, 1);
    chk("pre_rst_cnt", busy_cnt, 1);
    #1 rst = 1;
    #1;
    chk("async_rst_rdata", rdata1, 0);
    chk("async_rst_hazard", hazard, 0);
    chk("async_rst_cnt", busy_cnt, 0);
    rst = 0;
    ren2 = 0;
    tick();
    // same-cycle bypass then stored value
    we = 1; waddr = 3; wdata = 32'h12345678; raddr1 = 3; raddr2 = 3;
    #1;
    chk("bypass_p1", rdata1, 32'h12345678);
    chk("bypass_p2", rdata2, 32'h12345678);
    tick();
    idle();
    #1;
    chk("stored_p1", rdata1, 32'h12345678);
    // zero register ignores writes and issues
    we = 1; waddr = 0; wdata = 32'hFFFFFFFF; iss_en = 1; iss_addr = 0; raddr1 = 0; ren1 = 1;
    #1;
    chk("zero_bypass", rdata1, 0);
    tick();
    idle();
    #1;
    chk("zero_rdata", rdata1, 0);
    chk("zero_cnt", busy_cnt, 0);
    chk("zero_hazard", hazard, 0);
    ren1 = 0;
    // scoreboard: issue r9, hazard, clear via writeback bypass
    iss_en = 1; iss_addr = 9;
    tick();
    idle();
    raddr2 = 9; ren2 = 0;
    #1;
    chk("sb_unused_operand", hazard, 0);
    ren2 = 1;
    #1;
    chk("sb_hazard", hazard, 1);
    chk("sb_cnt1", busy_cnt, 1);
    we = 1; waddr = 9; wdata = 32'h99;
    #1;
    chk("sb_bypass_hazard", hazard, 0);
    chk("sb_bypass_data", rdata2, 32'h99);
    tick();
    idle();
    #1;
    chk("sb_cnt0", busy_cnt, 0);
    chk("sb_clear_hazard", hazard, 0);
    ren2 = 0;
    // simultaneous set and clear on a busy register
    iss_en = 1; iss_addr = 4;
    tick();
    iss_en = 1; iss_addr = 4; we = 1; waddr = 4; wdata = 32'h44;
    tick();
    idle();
    ren1 = 1; raddr1 = 4;
    #1;
    chk("sc_busy_cnt", busy_cnt, 1);
    chk("sc_busy_hazard", hazard, 1);
    chk("sc_busy_data", rdata1, 32'h44);
    // same on a non-busy register
    iss_en = 1; iss_addr = 6; we = 1; waddr = 6; wdata = 32'h66;
    tick();
    idle();
    raddr1 = 6;
    #1;
    chk("sc_free_cnt", busy_cnt, 2);
    chk("sc_free_hazard", hazard, 1);
    chk("sc_free_data", rdata1, 32'h66);
    // different addresses same cycle: clear r4, set r8
    iss_en = 1; iss_addr = 8; we = 1; waddr = 4; wdata = 32'h4040;
    tick();
    idle();
    raddr1 = 4;
    #1;
    chk("diff_cnt", busy_cnt, 2);
    chk("diff_r4_hazard", hazard, 0);
    raddr1 = 8;
    #1;
    chk("diff_r8_hazard", hazard, 1);
    // clearing a non-busy register and same-cycle issue visibility
    we = 1; waddr = 10; wdata = 32'hA;
    iss_en = 1; iss_addr = 11; raddr1 = 11;
    #1;
    chk("issue_not_yet_hazard", hazard, 0);
    tick();
    idle();
    #1;
    chk("issue_next_hazard", hazard, 1);
    chk("clr_free_cnt", busy_cnt, 3);
    ren1 = 0;
    // 24-register instance: out-of-range address 30
    b_we = 1; b_waddr = 30; b_wdata = 32'hAAAA; b_iss_en = 1; b_iss_addr = 30; b_raddr1 = 30; b_ren1 = 1;
    #1;
    chk("b_oor_bypass", b_rdata1, 0);
    tick();
    idle();
    #1;
    chk("b_oor_rdata", b_rdata1, 0);
    chk("b_oor_cnt", b_busy_cnt, 0);
    chk("b_oor_hazard", b_hazard, 0);
    b_we = 1; b_waddr = 23; b_wdata = 32'h2323;
    tick();
    idle();
    b_raddr1 = 23;
    #1;
    chk("b_top_rdata", b_rdata1, 32'h2323);
    for (int i = 1; i < 24; i++) begin
      b_iss_en = 1; b_iss_addr = 5'(i);
      tick();
    end
    idle();
    #1;
    chk("b_full_cnt", b_busy_cnt, 23);
    chk("b_full_hazard", b_hazard, 1);
    b_iss_en = 1; b_iss_addr = 5;
    tick();
    idle();
    #1;
    chk("b_reissue_cnt", b_busy_cnt, 23);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
